// File: rtl/fma_issue_arbiter.sv
// Round-robin issue arbiter sharing one FMA unit between two requesters, with fixed-latency result return.
// Optional accrued-flags register enabled by defining FMA_FFLAGS_ACCRUE_EN.
module fma_issue_arbiter #(
   parameter int PARM_XLEN = 32,
   parameter int PARM_RM   = 3,
   parameter int MAC_LAT   = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             req_valid_i,
   output logic [1:0]             req_ready_o,
   input  logic [2*PARM_RM-1:0]   req_rm_i,
   input  logic [2*PARM_XLEN-1:0] req_a_i,
   input  logic [2*PARM_XLEN-1:0] req_b_i,
   input  logic [2*PARM_XLEN-1:0] req_c_i,
   input  logic [PARM_RM-1:0]     frm_i,
   output logic [PARM_RM-1:0]     mac_rm_o,
   output logic [PARM_XLEN-1:0]   mac_a_o,
   output logic [PARM_XLEN-1:0]   mac_b_o,
   output logic [PARM_XLEN-1:0]   mac_c_o,
   input  logic [PARM_XLEN-1:0]   mac_result_i,
   input  logic [3:0]             mac_flags_i,
   output logic                   rsp_valid_o,
   output logic                   rsp_id_o,
   output logic [PARM_XLEN-1:0]   rsp_result_o,
   output logic [4:0]             rsp_flags_o,
   output logic                   rsp_illegal_o,
   output logic                   busy_o,
   input  logic                   fflags_clr_i,
   output logic [4:0]             fflags_o
);

   localparam logic [PARM_RM-1:0] RM_DYN = PARM_RM'(7);
   localparam logic [PARM_RM-1:0] RM_MAX = PARM_RM'(4);

   logic                 ptr_q;
   logic [1:0]           grant;
   logic                 accept;
   logic                 acc_id;
   logic [PARM_RM-1:0]   sel_rm;
   logic [PARM_RM-1:0]   eff_rm;
   logic                 acc_illegal;
   logic [PARM_XLEN-1:0] sel_a, sel_b, sel_c;

   logic                 iss_vld_q, iss_id_q, iss_ill_q;
   logic [PARM_RM-1:0]   mac_rm_q;
   logic [PARM_XLEN-1:0] mac_a_q, mac_b_q, mac_c_q;

   logic [MAC_LAT:0]     trk_vld_q, trk_vld_d;
   logic [MAC_LAT:0]     trk_id_q, trk_id_d;
   logic [MAC_LAT:0]     trk_ill_q, trk_ill_d;
   logic [PARM_XLEN-1:0] rsp_result_q;
   logic [4:0]           rsp_flags_q;

   // Grants are suppressed while reset is held so nothing is accepted during it.
   always_comb begin
      grant = 2'b00;
      if (!rst) begin
         case (req_valid_i)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   assign req_ready_o = grant;
   assign accept      = |grant;
   assign acc_id      = grant[1];

   assign sel_rm = acc_id ? req_rm_i[2*PARM_RM-1:PARM_RM]       : req_rm_i[PARM_RM-1:0];
   assign sel_a  = acc_id ? req_a_i[2*PARM_XLEN-1:PARM_XLEN]    : req_a_i[PARM_XLEN-1:0];
   assign sel_b  = acc_id ? req_b_i[2*PARM_XLEN-1:PARM_XLEN]    : req_b_i[PARM_XLEN-1:0];
   assign sel_c  = acc_id ? req_c_i[2*PARM_XLEN-1:PARM_XLEN]    : req_c_i[PARM_XLEN-1:0];

   // Dynamic mode substitutes frm; any resolved encoding above RNE..RMM is reserved.
   assign eff_rm      = (sel_rm == RM_DYN) ? frm_i : sel_rm;
   assign acc_illegal = (eff_rm > RM_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q     <= 1'b0;
         iss_vld_q <= 1'b0;
         iss_id_q  <= 1'b0;
         iss_ill_q <= 1'b0;
         mac_rm_q  <= '0;
         mac_a_q   <= '0;
         mac_b_q   <= '0;
         mac_c_q   <= '0;
      end else begin
         iss_vld_q <= accept;
         if (accept) begin
            ptr_q     <= ~acc_id;
            iss_id_q  <= acc_id;
            iss_ill_q <= acc_illegal;
            mac_rm_q  <= acc_illegal ? '0 : eff_rm;
            mac_a_q   <= acc_illegal ? '0 : sel_a;
            mac_b_q   <= acc_illegal ? '0 : sel_b;
            mac_c_q   <= acc_illegal ? '0 : sel_c;
         end
      end
   end

   assign mac_rm_o = mac_rm_q;
   assign mac_a_o  = mac_a_q;
   assign mac_b_o  = mac_b_q;
   assign mac_c_o  = mac_c_q;

   // Tracking shift register; the last stage doubles as the response register.
   genvar gi;
   generate
      for (gi = 0; gi <= MAC_LAT; gi++) begin : g_trk
         if (gi == 0) begin : g_head
            assign trk_vld_d[gi] = iss_vld_q;
            assign trk_id_d[gi]  = iss_id_q;
            assign trk_ill_d[gi] = iss_ill_q;
         end else begin : g_body
            assign trk_vld_d[gi] = trk_vld_q[gi-1];
            assign trk_id_d[gi]  = trk_id_q[gi-1];
            assign trk_ill_d[gi] = trk_ill_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         trk_vld_q    <= '0;
         trk_id_q     <= '0;
         trk_ill_q    <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
      end else begin
         trk_vld_q <= trk_vld_d;
         for (int k = 0; k < MAC_LAT; k++) begin
            trk_id_q[k]  <= trk_id_d[k];
            trk_ill_q[k] <= trk_ill_d[k];
         end
         if (trk_vld_d[MAC_LAT]) begin
            trk_id_q[MAC_LAT]  <= trk_id_d[MAC_LAT];
            trk_ill_q[MAC_LAT] <= trk_ill_d[MAC_LAT];
            rsp_result_q       <= trk_ill_d[MAC_LAT] ? '0 : mac_result_i;
            rsp_flags_q        <= trk_ill_d[MAC_LAT] ? 5'b0
                                  : {mac_flags_i[3], 1'b0, mac_flags_i[2:0]};
         end
      end
   end

   assign rsp_valid_o   = trk_vld_q[MAC_LAT];
   assign rsp_id_o      = trk_id_q[MAC_LAT];
   assign rsp_illegal_o = trk_ill_q[MAC_LAT];
   assign rsp_result_o  = rsp_result_q;
   assign rsp_flags_o   = rsp_flags_q;
   assign busy_o        = iss_vld_q | (|trk_vld_q);

`ifdef FMA_FFLAGS_ACCRUE_EN
   logic [4:0] fflags_q, fflags_d;

   // A clear coinciding with a response keeps only that response's flags.
   always_comb begin
      fflags_d = fflags_q;
      if (fflags_clr_i) fflags_d = 5'b0;
      if (rsp_valid_o && !rsp_illegal_o) fflags_d = fflags_d | rsp_flags_o;
   end

   always_ff @(posedge clk) begin
      if (rst) fflags_q <= 5'b0;
      else     fflags_q <= fflags_d;
   end

   assign fflags_o = fflags_q;
`else
   logic unused_fflags_clr;
   assign unused_fflags_clr = fflags_clr_i;
   assign fflags_o          = 5'b0;
`endif

endmodule
